// File: rtl/adc_lane_align.sv
// ADC data-lane back end: per-lane training-word alignment via bitslip, then sign-extended samples.
// Optional ADC_LANE_OFFSET_BIN_EN: treat lane words as offset-binary on the datapath.
module adc_lane_align #(
  parameter int          ADC_BITS      = 14,
  parameter int          LANES         = 4,
  parameter logic [15:0] TRAIN_PATTERN = 16'h2A5F,
  parameter int          MATCH_COUNT   = 8,
  parameter int          SLIP_WAIT     = 3,
  parameter int          MAX_SLIPS     = ADC_BITS
) (
  input  logic                      DatClkDiv,
  input  logic                      DatRstn,
  input  logic                      FrmAlignDone,
  input  logic                      AlignStart,
  input  logic [LANES*ADC_BITS-1:0] LaneData,
  output logic [LANES-1:0]          LaneBitslip,
  output logic [LANES-1:0]          LaneLocked,
  output logic [LANES*16-1:0]       DatData,
  output logic                      DatValid,
  output logic                      DatAlignDone,
  output logic                      AlignFail
);

  localparam int                  SLIP_CW    = $clog2(MAX_SLIPS + 1);
  localparam logic [ADC_BITS-1:0] TRAIN_WORD = TRAIN_PATTERN[ADC_BITS-1:0];
  localparam logic [7:0]          MATCH_LAST = 8'(MATCH_COUNT);
  localparam logic [SLIP_CW-1:0]  SLIP_LAST  = SLIP_CW'(MAX_SLIPS);
  localparam logic [3:0]          WAIT_LAST  = 4'(SLIP_WAIT - 1);

  typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL} laneState_e;

  function automatic logic signed [15:0] signExtend(input logic [ADC_BITS-1:0] raw);
    logic signed [ADC_BITS-1:0] word;
    word = raw;
`ifdef ADC_LANE_OFFSET_BIN_EN
    word[ADC_BITS-1] = ~raw[ADC_BITS-1];
`endif
    return 16'(word);
  endfunction

  logic [LANES*ADC_BITS-1:0] rawQ_p1;
  logic [LANES*16-1:0]       datData_p2;
  logic [LANES-1:0]          laneFail;
  logic                      alignDone_p1;
  logic                      alignFail_p1;
  logic                      vld_p2;

  // Stage 1: raw deserialiser capture
  always_ff @(posedge DatClkDiv or negedge DatRstn) begin
    if (!DatRstn) rawQ_p1 <= '0;
    else          rawQ_p1 <= LaneData;
  end

  // Stage 2: sign-extended samples, lock/fail status, and valid
  always_ff @(posedge DatClkDiv or negedge DatRstn) begin
    if (!DatRstn) begin
      datData_p2   <= '0;
      alignDone_p1 <= 1'b0;
      alignFail_p1 <= 1'b0;
      vld_p2       <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++)
        datData_p2[i*16 +: 16] <= signExtend(rawQ_p1[i*ADC_BITS +: ADC_BITS]);
      // Losing frame alignment clears status at once rather than waiting for the lanes to idle
      alignDone_p1 <= FrmAlignDone & (&LaneLocked);
      alignFail_p1 <= FrmAlignDone & (|laneFail);
      vld_p2       <= alignDone_p1;
    end
  end

  assign DatData      = datData_p2;
  assign DatAlignDone = alignDone_p1;
  assign AlignFail    = alignFail_p1;
  assign DatValid     = vld_p2;

  for (genvar i = 0; i < LANES; i++) begin : gLane
    laneState_e         state, stateNext;
    logic [7:0]         matchCnt, matchCntNext;
    logic [SLIP_CW-1:0] slipCnt, slipCntNext;
    logic [3:0]         waitCnt, waitCntNext;
    logic               isMatch;

    assign isMatch = (rawQ_p1[i*ADC_BITS +: ADC_BITS] == TRAIN_WORD);

    always_ff @(posedge DatClkDiv or negedge DatRstn) begin
      if (!DatRstn) begin
        state    <= IDLE;
        matchCnt <= '0;
        slipCnt  <= '0;
        waitCnt  <= '0;
      end else begin
        state    <= stateNext;
        matchCnt <= matchCntNext;
        slipCnt  <= slipCntNext;
        waitCnt  <= waitCntNext;
      end
    end

    always_comb begin
      stateNext    = state;
      matchCntNext = matchCnt;
      slipCntNext  = slipCnt;
      waitCntNext  = waitCnt;
      if (!FrmAlignDone || AlignStart) begin
        stateNext    = FrmAlignDone ? CHECK : IDLE;
        matchCntNext = '0;
        slipCntNext  = '0;
        waitCntNext  = '0;
      end else begin
        case (state)
          IDLE: begin
            stateNext    = CHECK;
            matchCntNext = '0;
            slipCntNext  = '0;
          end
          CHECK: begin
            if (matchCnt == MATCH_LAST) begin
              stateNext = LOCKED;
            end else if (isMatch) begin
              matchCntNext = matchCnt + 8'd1;
            end else begin
              matchCntNext = '0;
              stateNext    = (slipCnt == SLIP_LAST) ? FAIL : SLIP;
            end
          end
          SLIP: begin
            slipCntNext = slipCnt + 1'b1;
            waitCntNext = '0;
            stateNext   = WAIT;
          end
          WAIT: begin
            // Deserialiser output is unsettled here, so RawQ is not compared
            if (waitCnt == WAIT_LAST) stateNext = CHECK;
            else                      waitCntNext = waitCnt + 4'd1;
          end
          default: ;
        endcase
      end
    end

    assign LaneBitslip[i] = (state == SLIP);
    assign LaneLocked[i]  = (state == LOCKED);
    assign laneFail[i]    = (state == FAIL);
  end

endmodule

// File: tb/tb_adc_lane_align.sv
// Bench for adc_lane_align (14-bit, 2 lanes): directed training scenarios against a
// cycle-level behavioural model, plus hand-derived timing and data checkpoints.
`timescale 1ns/1ps
module tb_adc_lane_align;
  localparam int          AB    = 14;
  localparam int          LN    = 2;
  localparam int          MC    = 8;
  localparam int          SW    = 3;
  localparam int          MS    = 14;
  localparam logic [13:0] TRAIN = 14'h2A5F;
`ifdef ADC_LANE_OFFSET_BIN_EN
  localparam logic [15:0] X3FFF = 16'h1FFF, X1FFF = 16'hFFFF, X0000 = 16'hE000, X2000 = 16'h0000, XTRN = 16'h0A5F;
`else
  localparam logic [15:0] X3FFF = 16'hFFFF, X1FFF = 16'h1FFF, X0000 = 16'h0000, X2000 = 16'hE000, XTRN = 16'hEA5F;
`endif

  logic             DatClkDiv = 1'b0;
  logic             DatRstn, FrmAlignDone, AlignStart;
  logic [LN*AB-1:0] LaneData;
  logic [LN-1:0]    LaneBitslip, LaneLocked;
  logic [LN*16-1:0] DatData;
  logic             DatValid, DatAlignDone, AlignFail;

  adc_lane_align #(.ADC_BITS(AB), .LANES(LN), .TRAIN_PATTERN(16'h2A5F), .MATCH_COUNT(MC),
                   .SLIP_WAIT(SW), .MAX_SLIPS(MS)) dut (
    .DatClkDiv(DatClkDiv), .DatRstn(DatRstn), .FrmAlignDone(FrmAlignDone),
    .AlignStart(AlignStart), .LaneData(LaneData), .LaneBitslip(LaneBitslip),
    .LaneLocked(LaneLocked), .DatData(DatData), .DatValid(DatValid),
    .DatAlignDone(DatAlignDone), .AlignFail(AlignFail));

  always #5 DatClkDiv = ~DatClkDiv;

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;

  // Stimulus sources: fixed word, or a deserialiser that rotates one bit per bitslip
  logic [13:0] laneWord [LN];
  bit          rotMode  [LN];
  int          rotOff   [LN];
  int          pulseCnt [LN];
  int          lastPulse[LN];
  int          gapErr   [LN];

  // Behavioural model
  logic [LN-1:0] mActive, mLocked, mFailed, mPulse;
  int            mStreak[LN], mSlips[LN], mHold[LN];
  logic [13:0]   mRaw[LN];
  logic [15:0]   mData[LN];
  logic          mDone, mFailOut, mValid;

  function automatic logic [13:0] rotl(input logic [13:0] w, input int k);
    logic [27:0] dbl;
    dbl = {w, w};
    return dbl[27-k -: 14];
  endfunction

  function automatic logic [15:0] expSext(input logic [13:0] w);
    int v;
`ifdef ADC_LANE_OFFSET_BIN_EN
    w = w ^ 14'h2000;
`endif
    v = int'(w);
    if (v >= 8192) v = v - 16384;
    return 16'(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clearLane(input int i);
    mLocked[i] = 1'b0; mFailed[i] = 1'b0;
    mStreak[i] = 0; mSlips[i] = 0; mHold[i] = 0;
  endtask

  task automatic modelReset();
    mActive = '0; mPulse = '0; mDone = 1'b0; mFailOut = 1'b0; mValid = 1'b0;
    for (int i = 0; i < LN; i++) begin
      clearLane(i);
      mRaw[i] = '0; mData[i] = '0;
    end
  endtask

  task automatic laneEdge(input int i, input bit hit);
    mPulse[i] = 1'b0;
    if (!FrmAlignDone) begin
      mActive[i] = 1'b0; clearLane(i);
    end else if (AlignStart || !mActive[i]) begin
      mActive[i] = 1'b1; clearLane(i);
    end else if (mLocked[i] || mFailed[i]) begin
    end else if (mHold[i] > 0) begin
      mHold[i]--;
    end else if (mStreak[i] == MC) begin
      mLocked[i] = 1'b1;
    end else if (hit) begin
      mStreak[i]++;
    end else begin
      mStreak[i] = 0;
      if (mSlips[i] == MS) mFailed[i] = 1'b1;
      else begin mPulse[i] = 1'b1; mSlips[i]++; mHold[i] = SW + 1; end
    end
  endtask

  task automatic modelEdge();
    if (!DatRstn) begin modelReset(); return; end
    mValid   = mDone;
    mDone    = FrmAlignDone && (&mLocked);
    mFailOut = FrmAlignDone && (|mFailed);
    for (int i = 0; i < LN; i++) begin
      mData[i] = expSext(mRaw[i]);
      laneEdge(i, mRaw[i] == TRAIN);
    end
    for (int i = 0; i < LN; i++) mRaw[i] = LaneData[i*AB +: AB];
  endtask

  task automatic compareAll();
    chk("bitslip", LaneBitslip, mPulse);
    chk("locked", LaneLocked, mLocked);
    chk("align_done", DatAlignDone, mDone);
    chk("align_fail", AlignFail, mFailOut);
    chk("valid", DatValid, mValid);
    chk("data", DatData, {mData[1], mData[0]});
  endtask

  task automatic drive();
    for (int i = 0; i < LN; i++)
      LaneData[i*AB +: AB] = rotMode[i] ? rotl(TRAIN, rotOff[i]) : laneWord[i];
  endtask

  task automatic clearStats();
    for (int i = 0; i < LN; i++) begin pulseCnt[i] = 0; lastPulse[i] = 0; gapErr[i] = 0; end
  endtask

  task automatic step();
    @(posedge DatClkDiv);
    modelEdge();
    @(negedge DatClkDiv);
    cyc++;
    compareAll();
    for (int i = 0; i < LN; i++) begin
      if (LaneBitslip[i] === 1'b1) begin
        if (pulseCnt[i] > 0 && (cyc - lastPulse[i]) != SW + 2) gapErr[i]++;
        pulseCnt[i]++;
        lastPulse[i] = cyc;
        if (rotMode[i]) rotOff[i] = (rotOff[i] + AB - 1) % AB;
      end
    end
    drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    DatRstn = 1'b0; FrmAlignDone = 1'b0; AlignStart = 1'b0;
    for (int i = 0; i < LN; i++) begin laneWord[i] = '0; rotMode[i] = 0; rotOff[i] = 0; end
    clearStats();
    drive();
    modelReset();
    #1;
    chk("rst_bitslip", LaneBitslip, 0);
    chk("rst_locked", LaneLocked, 0);
    chk("rst_flags", {DatValid, DatAlignDone, AlignFail}, 0);
    chk("rst_data", DatData, 0);
    repeat (3) step();
    DatRstn = 1'b1;
    repeat (2) step();

    // Both lanes already aligned: lock without slipping
    laneWord[0] = TRAIN; laneWord[1] = TRAIN; FrmAlignDone = 1'b1; drive();
    repeat (9) step();
    chk("t1_not_yet_locked", LaneLocked, 2'b00);
    step();
    chk("t1_locked", LaneLocked, 2'b11);
    chk("t1_done_lags", DatAlignDone, 0);
    step();
    chk("t1_done", DatAlignDone, 1);
    chk("t1_valid_lags", DatValid, 0);
    step();
    chk("t1_valid", DatValid, 1);
    chk("t1_no_slips", pulseCnt[0] + pulseCnt[1], 0);

    // Datapath sign extension, two cycles of latency
    laneWord[0] = 14'h3FFF; drive(); step();
    laneWord[0] = 14'h1FFF; drive(); step();
    chk("t5_3fff", DatData[15:0], X3FFF);
    laneWord[0] = 14'h0000; drive(); step();
    chk("t5_1fff", DatData[15:0], X1FFF);
    laneWord[0] = 14'h2000; drive(); step();
    chk("t5_0000", DatData[15:0], X0000);
    step();
    chk("t5_2000", DatData[15:0], X2000);
    chk("t5_lane1", DatData[31:16], XTRN);
    chk("t5_still_valid", DatValid, 1);

    // Frame alignment lost while locked
    FrmAlignDone = 1'b0; drive(); step();
    chk("t6a_unlocked", LaneLocked, 2'b00);
    chk("t6a_done_drop", DatAlignDone, 0);
    chk("t6a_valid_lags", DatValid, 1);
    step();
    chk("t6a_valid_drop", DatValid, 0);

    // Lane 1 starts three bits off
    laneWord[0] = TRAIN; rotMode[1] = 1; rotOff[1] = 3; clearStats();
    FrmAlignDone = 1'b1; drive();
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (DatAlignDone === 1'b1) seen = 1;
    end
    chk("t2_done_reached", seen, 1);
    chk("t2_lane1_slips", pulseCnt[1], 3);
    chk("t2_lane0_slips", pulseCnt[0], 0);
    chk("t2_slip_spacing", gapErr[1], 0);
    rotMode[1] = 0; laneWord[1] = TRAIN; drive();

    // Single mismatch after five matches
    clearStats(); AlignStart = 1'b1; drive(); step();
    AlignStart = 1'b0;
    repeat (4) step();
    laneWord[0] = 14'h0000; drive(); step();
    laneWord[0] = TRAIN; drive();
    repeat (13) step();
    chk("t4_lane0_pending", LaneLocked, 2'b10);
    step();
    chk("t4_lane0_locked", LaneLocked, 2'b11);
    chk("t4_one_slip", pulseCnt[0], 1);
    chk("t4_lane1_no_slip", pulseCnt[1], 0);

    // Lane 0 never matches: exhaust slips, fail, then retrain
    clearStats(); laneWord[0] = 14'h0000; AlignStart = 1'b1; drive(); step();
    AlignStart = 1'b0;
    repeat (71) step();
    chk("t3_fail_not_yet", AlignFail, 0);
    chk("t3_slip_count", pulseCnt[0], 14);
    step();
    chk("t3_fail", AlignFail, 1);
    chk("t3_not_done", DatAlignDone, 0);
    repeat (5) step();
    chk("t3_slips_stop", pulseCnt[0], 14);
    clearStats(); AlignStart = 1'b1; drive(); step();
    AlignStart = 1'b0;
    chk("t3_fail_lags", AlignFail, 1);
    step();
    chk("t3_fail_cleared", AlignFail, 0);
    chk("t3_slip_restart", LaneBitslip, 2'b01);

    // Frame alignment lost during WAIT
    step();
    FrmAlignDone = 1'b0; drive(); step();
    chk("t6_bitslip_low", LaneBitslip, 2'b00);
    chk("t6_locked_low", LaneLocked, 2'b00);
    repeat (6) step();
    chk("t6_no_more_slips", pulseCnt[0], 1);

    // Async reset in the middle of a SLIP cycle
    FrmAlignDone = 1'b1; drive();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (LaneBitslip[0] === 1'b1) seen = 1;
    end
    chk("t6_slip_seen", seen, 1);
    #2;
    DatRstn = 1'b0;
    modelReset();
    #1;
    chk("t6_rst_bitslip", LaneBitslip, 0);
    chk("t6_rst_data", DatData, 0);
    chk("t6_rst_flags", {LaneLocked, DatValid, DatAlignDone, AlignFail}, 0);
    repeat (2) step();
    DatRstn = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/adc_lane_align.md
Name: adc_lane_align

Overview:
Multi-lane, parametrised ADC data-lane back end that sits in the DatClkDiv domain, directly after the per-lane deserialisers. It registers the raw parallel words from LANES deserialisers. It runs an independent per-lane training-pattern word-alignment FSM that drives one BITSLIP pulse per slip into each lane's deserialiser. Aligned words are sign-extended to 16 bits and presented with a common valid once every lane is locked.

Parameters:
ADC_BITS, 14, sample width per lane; legal 8..16
LANES, 4, number of data lanes; legal 1..16
TRAIN_PATTERN, 16'h2A5F, training word; low ADC_BITS bits compared
MATCH_COUNT, 8, consecutive matches required for lock; legal 1..255
SLIP_WAIT, 3, settle cycles after each bitslip pulse; legal 1..15
MAX_SLIPS, ADC_BITS, slips attempted before a lane declares failure

Ports:
DatClkDiv  in  1  divided word clock; the only clock
DatRstn  in  1  asynchronous active-low reset
FrmAlignDone  in  1  frame-lane alignment complete; level
AlignStart  in  1  single-cycle retrain request
LaneData  in  LANES*ADC_BITS  raw deserialiser words; lane i at [i*ADC_BITS +: ADC_BITS]
LaneBitslip  out  LANES  one-cycle bitslip pulse per lane
LaneLocked  out  LANES  per-lane lock status
DatData  out  LANES*16  sign-extended samples; lane i at [i*16 +: 16]
DatValid  out  1  DatData qualified
DatAlignDone  out  1  all lanes locked
AlignFail  out  1  at least one lane failed

Behaviour:
- Reset (DatRstn=0, async): all FSMs IDLE, all counters 0. LaneBitslip, LaneLocked, DatData, DatValid, DatAlignDone and AlignFail are 0.
- Stage 1: LaneData registered every cycle into RawQ. All compares use RawQ.
- Per-lane FSM, states IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL:
  - IDLE: on FrmAlignDone=1, go to CHECK with match_cnt=0 and slip_cnt=0.
  - CHECK on RawQ==TRAIN_PATTERN[ADC_BITS-1:0]: match_cnt++. When match_cnt reaches MATCH_COUNT, go to LOCKED on the next cycle.
  - CHECK on mismatch: match_cnt=0. If slip_cnt==MAX_SLIPS, go to FAIL; otherwise go to SLIP.
  - SLIP: lasts exactly 1 cycle. LaneBitslip[i]=1 (registered output, high only in this state). slip_cnt++. Then go to WAIT.
  - WAIT: SLIP_WAIT cycles, RawQ ignored, then CHECK.
  - Consecutive pulses on a never-matching lane are therefore SLIP_WAIT+2 cycles apart.
  - LOCKED: LaneLocked[i]=1. Holds, with no further compares.
  - FAIL: holds until a restart.
- Priority, highest first:
  1. FrmAlignDone=0 forces every lane to IDLE next cycle, clears counters, drops LaneBitslip. This applies in any state, including SLIP or WAIT.
  2. AlignStart=1 with FrmAlignDone=1 forces every lane to CHECK with counters cleared, from any state.
  3. Normal transitions.
- Status outputs:
  - DatAlignDone is registered: AND of all LaneLocked.
  - AlignFail is registered: OR of lanes in FAIL.
  - DatAlignDone and AlignFail are never both 1 for LANES=1.
- Datapath:
  - DatData lane i is registered from RawQ, sign-extended: bit ADC_BITS-1 replicated into bits 15..ADC_BITS. For ADC_BITS=16 it passes through.
  - Latency LaneData -> DatData is 2 cycles. Updated every cycle regardless of lock.
  - DatValid = DatAlignDone delayed by 1 cycle, so it asserts on the first DatData cycle taken after all lanes are locked. It deasserts 1 cycle after DatAlignDone falls.
- Lanes are independent: a locked lane does not slip while another lane trains.

Optional Feature:
Macro ADC_LANE_OFFSET_BIN_EN.
- Defined: before sign-extension, bit ADC_BITS-1 of RawQ is inverted (offset-binary to two's-complement) on the datapath only. The training compare still uses the uninverted RawQ.
- Not defined: straight two's-complement, no inversion.

Test Plan:
1. ADC_BITS=14, LANES=2, both lanes constant 14'h2A5F, FrmAlignDone 0->1 -> no LaneBitslip pulse. LaneLocked=2'b11 nine cycles after first CHECK. DatAlignDone next cycle, DatValid one cycle later.
2. Lane 1 model rotates its word one bit per bitslip, starting 3 bits off -> exactly 3 LaneBitslip[1] pulses, 5 cycles apart. Lane 0 has none. Then lock, DatAlignDone=1.
3. Lane 0 always 14'h0000 -> 14 pulses on LaneBitslip[0], then AlignFail=1. DatAlignDone stays 0. AlignStart pulse -> AlignFail back to 0 and slips restart.
4. Lane 0 matches 5 cycles, mismatches once, then matches -> one slip pulse, match_cnt restarts, lock only after 8 further matches.
5. After lock, LaneData lane 0 = 14'h3FFF, then 14'h1FFF -> DatData[15:0]=16'hFFFF, then 16'h1FFF, each 2 cycles after input. With ADC_LANE_OFFSET_BIN_EN, 14'h0000 -> 16'hE000.
6. FrmAlignDone drops during WAIT -> next cycle all FSMs IDLE, LaneBitslip=0, DatAlignDone=0, DatValid=0 one cycle later. DatRstn pulsed low mid-SLIP -> all outputs 0 immediately.
